// File: rtl/m_pat_chk.sv
// Receive-side checker for the wrap-around counting pattern (0..LIM, 0, ...).
// It acquires lock, flywheels through isolated upsets, and keeps a saturating error count.
module m_pat_chk #(
  parameter int N          = 4,
  parameter int LIM        = 14,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [N-1:0]     data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [N-1:0]  LIM_V    = N'(LIM);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2,
    MISS = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  exp_val, exp_n;
  logic [GW-1:0] good_cnt, good_n, good_inc;
  logic [BW-1:0] bad_cnt, bad_n, bad_inc;
  logic          err_n, hit, in_rng;

  // LIM is at most 2^N-1, so x+1 is only taken when it cannot overflow N bits
  function automatic logic [N-1:0] nxt(input logic [N-1:0] x);
    return (x == LIM_V) ? '0 : x + N'(1);
  endfunction

  assign hit      = (data_i == exp_val);
  assign in_rng   = (data_i <= LIM_V);
  assign good_inc = good_cnt + GW'(1);
  assign bad_inc  = bad_cnt + BW'(1);

  always_comb begin
    state_n = state;
    exp_n   = exp_val;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    err_n   = 1'b0;
    if (en_i) begin
      case (state)
        HUNT: begin
          if (in_rng) begin
            exp_n   = nxt(data_i);
            good_n  = GW'(1);
            state_n = (LOCK_CNT == 1) ? LOCK : SYNC;
          end
        end
        SYNC: begin
          if (hit) begin
            exp_n  = nxt(exp_val);
            good_n = good_inc;
            if (good_inc == LOCK_V) state_n = LOCK;
          end else if (in_rng) begin
            exp_n  = nxt(data_i);
            good_n = GW'(1);
          end else begin
            state_n = HUNT;
          end
        end
        LOCK: begin
          // flywheel: expected value advances whether or not the sample matched
          exp_n = nxt(exp_val);
          if (!hit) begin
            err_n   = 1'b1;
            bad_n   = BW'(1);
            state_n = (UNLOCK_CNT == 1) ? HUNT : MISS;
          end
        end
        MISS: begin
          exp_n = nxt(exp_val);
          if (hit) begin
            bad_n   = '0;
            state_n = LOCK;
          end else begin
            err_n = 1'b1;
            bad_n = bad_inc;
            if (bad_inc == UNLOCK_V) state_n = HUNT;
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= HUNT;
      exp_val   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_o     <= 1'b0;
      locked_o  <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      state    <= state_n;
      exp_val  <= exp_n;
      good_cnt <= good_n;
      bad_cnt  <= bad_n;
      err_o    <= err_n;
      locked_o <= (state_n == LOCK) || (state_n == MISS);
      // clear wins over a coincident error; the pulse itself still goes out
      if (clr_i)
        err_cnt_o <= '0;
      else if (err_n && (err_cnt_o != '1))
        err_cnt_o <= err_cnt_o + ERR_W'(1);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_m_pat_chk.sv
// Directed vector bench for m_pat_chk; a second instance with a 2-bit counter
// shares the stimulus to exercise saturation.
module tb_m_pat_chk;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic [3:0]  data_i;
  logic        clr_i;
  logic        locked_o, err_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  state_o;
  logic        s_locked, s_err;
  logic [1:0]  s_cnt;
  logic [1:0]  s_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [3:0]  data;
    logic        clr;
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  state;
    logic [1:0]  scnt;
  } vec_t;

  vec_t vq[$];

  m_pat_chk #(.N(4), .LIM(14), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .clr_i(clr_i),
    .locked_o(locked_o), .err_o(err_o), .err_cnt_o(err_cnt_o), .state_o(state_o)
  );

  m_pat_chk #(.N(4), .LIM(14), .LOCK_CNT(4), .UNLOCK_CNT(3), .ERR_W(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i), .clr_i(clr_i),
    .locked_o(s_locked), .err_o(s_err), .err_cnt_o(s_cnt), .state_o(s_state)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void add(input logic en, input logic [3:0] d, input logic clr,
                              input logic lk, input logic er, input int cnt,
                              input logic [1:0] st);
    vec_t v;
    v.en = en; v.data = d; v.clr = clr;
    v.locked = lk; v.err = er; v.cnt = 16'(cnt); v.state = st;
    v.scnt = (cnt > 3) ? 2'd3 : 2'(cnt);
    vq.push_back(v);
  endfunction

  task automatic apply(input vec_t v, input int idx);
    en_i = v.en; data_i = v.data; clr_i = v.clr;
    @(posedge clk_i);
    #1;
    chk($sformatf("v%0d state", idx),   32'(state_o),   32'(v.state));
    chk($sformatf("v%0d locked", idx),  32'(locked_o),  32'(v.locked));
    chk($sformatf("v%0d err", idx),     32'(err_o),     32'(v.err));
    chk($sformatf("v%0d cnt", idx),     32'(err_cnt_o), 32'(v.cnt));
    chk($sformatf("v%0d sat_cnt", idx), 32'(s_cnt),     32'(v.scnt));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " state"},   32'(state_o),   32'd0);
    chk({tag, " locked"},  32'(locked_o),  32'd0);
    chk({tag, " err"},     32'(err_o),     32'd0);
    chk({tag, " cnt"},     32'(err_cnt_o), 32'd0);
    chk({tag, " sat_cnt"}, 32'(s_cnt),     32'd0);
  endtask

  initial begin
    rst_i = 1'b0; en_i = 1'b0; data_i = '0; clr_i = 1'b0;
    #12;
    chk_reset("reset");
    rst_i = 1'b1;

    // acquisition: >3 wraps of 0..14, lock after 4th sample
    for (int i = 0; i < 50; i++)
      add(1'b1, 4'(i % 15), 1'b0, (i >= 3), 1'b0, 0, (i < 3) ? 2'd1 : 2'd2);
    // single upset at expected 7
    add(1, 5, 0, 1, 0, 0, 2);
    add(1, 6, 0, 1, 0, 0, 2);
    add(1, 15, 0, 1, 1, 1, 3);
    add(1, 8, 0, 1, 0, 1, 2);
    add(1, 9, 0, 1, 0, 1, 2);
    // idle clear, state holds
    add(0, 0, 1, 1, 0, 0, 2);
    for (int i = 10; i <= 19; i++)
      add(1'b1, 4'(i % 15), 1'b0, 1'b1, 1'b0, 0, 2'd2);
    // loss of lock: expected 5,6,7, received 0,0,0
    add(1, 0, 0, 1, 1, 1, 3);
    add(1, 0, 0, 1, 1, 2, 3);
    add(1, 0, 0, 0, 1, 3, 0);
    // re-lock from flywheeled position
    add(1, 8, 0, 0, 0, 3, 1);
    add(1, 9, 0, 0, 0, 3, 1);
    add(1, 10, 0, 0, 0, 3, 1);
    add(1, 11, 0, 1, 0, 3, 2);
    // stall with garbage on idle cycles
    add(1, 12, 0, 1, 0, 3, 2);
    add(0, 15, 0, 1, 0, 3, 2);
    add(0, 15, 0, 1, 0, 3, 2);
    add(1, 13, 0, 1, 0, 3, 2);
    // clear coincident with counted mismatch (expected 14)
    add(1, 0, 1, 1, 1, 0, 3);
    add(1, 0, 0, 1, 0, 0, 2);
    // 5 misses alternating MISS/LOCK; 2-bit counter pins at 3
    for (int k = 0; k < 5; k++) begin
      add(1'b1, 4'd15, 1'b0, 1'b1, 1'b1, k + 1, 2'd3);
      add(1'b1, 4'(2 * k + 2), 1'b0, 1'b1, 1'b0, k + 1, 2'd2);
    end
    foreach (vq[i]) apply(vq[i], i);

    // enter MISS (expected 11), then reset between edges
    vq.delete();
    add(1, 15, 0, 1, 1, 6, 3);
    apply(vq[0], 1000);
    #3;
    rst_i = 1'b0;
    #1;
    chk_reset("async_reset");
    en_i = 1'b0;
    @(posedge clk_i);
    #2;
    chk_reset("held_reset");
    rst_i = 1'b1;

    vq.delete();
    add(1, 15, 0, 0, 0, 0, 0);
    add(1, 15, 0, 0, 0, 0, 0);
    add(1, 3, 0, 0, 0, 0, 1);
    add(1, 4, 0, 0, 0, 0, 1);
    add(1, 5, 0, 0, 0, 0, 1);
    add(1, 6, 0, 1, 0, 0, 2);
    add(1, 7, 0, 1, 0, 0, 2);
    foreach (vq[i]) apply(vq[i], 2000 + i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
